// File: rtl/csr_access_responder_pkg.sv
// Shared CSR definitions: operation codes, machine-CSR addresses, register index,
// FSM state type and mstatus bit positions.
package p_hardisc;

  localparam logic [1:0] CSR_RW = 2'b01;
  localparam logic [1:0] CSR_RS = 2'b10;
  localparam logic [1:0] CSR_RC = 2'b11;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MHRDCTRL0 = 12'h7C0;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [3:0] {
    IDX_MSTATUS, IDX_MISA, IDX_MIE, IDX_MTVEC, IDX_MSCRATCH, IDX_MEPC,
    IDX_MCAUSE, IDX_MTVAL, IDX_MIP, IDX_MHRDCTRL0, IDX_MCYCLE, IDX_MCYCLEH,
    IDX_MINSTRET, IDX_MINSTRETH, IDX_MHARTID, IDX_NONE
  } csr_idx_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  function automatic csr_idx_e csr_decode(input logic [11:0] add);
    case (add)
      ADDR_MSTATUS:   return IDX_MSTATUS;
      ADDR_MISA:      return IDX_MISA;
      ADDR_MIE:       return IDX_MIE;
      ADDR_MTVEC:     return IDX_MTVEC;
      ADDR_MSCRATCH:  return IDX_MSCRATCH;
      ADDR_MEPC:      return IDX_MEPC;
      ADDR_MCAUSE:    return IDX_MCAUSE;
      ADDR_MTVAL:     return IDX_MTVAL;
      ADDR_MIP:       return IDX_MIP;
      ADDR_MHRDCTRL0: return IDX_MHRDCTRL0;
      ADDR_MCYCLE:    return IDX_MCYCLE;
      ADDR_MCYCLEH:   return IDX_MCYCLEH;
      ADDR_MINSTRET:  return IDX_MINSTRET;
      ADDR_MINSTRETH: return IDX_MINSTRETH;
      ADDR_MHARTID:   return IDX_MHARTID;
      default:        return IDX_NONE;
    endcase
  endfunction

endpackage

// File: rtl/csr_access_responder_if.sv
// Request/response handshake bundle between the CSR requester and responder.
interface csr_access_responder_if;
  logic        s_req_val_i;
  logic        s_req_rdy_o;
  logic [1:0]  s_req_op_i;
  logic [11:0] s_req_add_i;
  logic [31:0] s_req_wdata_i;
  logic        s_rsp_val_o;
  logic        s_rsp_rdy_i;
  logic [31:0] s_rsp_rdata_o;
  logic        s_rsp_ill_o;

  modport master (
    output s_req_val_i, s_req_op_i, s_req_add_i, s_req_wdata_i, s_rsp_rdy_i,
    input  s_req_rdy_o, s_rsp_val_o, s_rsp_rdata_o, s_rsp_ill_o
  );

  modport slave (
    input  s_req_val_i, s_req_op_i, s_req_add_i, s_req_wdata_i, s_rsp_rdy_i,
    output s_req_rdy_o, s_rsp_val_o, s_rsp_rdata_o, s_rsp_ill_o
  );
endinterface

// File: rtl/csr_access_responder_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; a write
// replaces one half and suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_cnt
);
  logic [63:0] r_cnt;

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i)  r_cnt         <= '0;
    else if (i_wr_lo) r_cnt[31:0]   <= i_wdata;
    else if (i_wr_hi) r_cnt[63:32]  <= i_wdata;
    else if (i_inc)   r_cnt         <= r_cnt + 64'd1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/csr_access_responder.sv
// Machine-CSR responder: IDLE/ACCESS/RESP handshake, read-modify-write of CSR storage.
// Optional cycle/instret counters are built when CSR_COUNTERS_EN is defined.
module csr_access_responder
  import p_hardisc::*;
#(
  parameter logic [31:0] HARTID    = 32'd0,
  parameter logic [31:0] ISA_VAL   = 32'h40001106,
  parameter logic [31:0] MTVEC_RST = 32'h80000000
) (
  input  logic                   s_clk_i,
  input  logic                   s_resetn_i,
  csr_access_responder_if.slave  s_bus,
  input  logic                   s_retire_i,
  input  logic [2:0]             s_irq_i,
  output logic [31:0]            s_mtvec_o,
  output logic [31:0]            s_mepc_o,
  output logic [31:0]            s_mie_o,
  output logic [31:0]            s_hrdctrl0_o,
  output logic                   s_gie_o
);
  state_e      r_state;
  logic        r_req_rdy, r_rsp_val, r_rsp_ill;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_op;
  logic [11:0] r_add;
  logic [31:0] r_wdata;
  logic        r_mst_mie, r_mst_mpie;
  logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_hrdctrl0;

  csr_idx_e    w_idx;
  logic [31:0] w_old, w_new;
  logic        w_mapped, w_wr_eff, w_ill, w_commit;

  assign w_idx = csr_decode(r_add);

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret;

  csr_counter64 u_mcycle (
    .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i), .i_inc(1'b1),
    .i_wr_lo(w_commit && (w_idx == IDX_MCYCLE)),
    .i_wr_hi(w_commit && (w_idx == IDX_MCYCLEH)),
    .i_wdata(w_new), .o_cnt(w_mcycle)
  );

  csr_counter64 u_minstret (
    .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i), .i_inc(s_retire_i),
    .i_wr_lo(w_commit && (w_idx == IDX_MINSTRET)),
    .i_wr_hi(w_commit && (w_idx == IDX_MINSTRETH)),
    .i_wdata(w_new), .o_cnt(w_minstret)
  );
`else
  logic w_unused_retire;
  assign w_unused_retire = s_retire_i;
`endif

  always_comb begin
    w_old    = '0;
    w_mapped = 1'b1;
    case (w_idx)
      IDX_MSTATUS: begin
        w_old[MSTATUS_MPP_LO +: 2] = 2'b11;
        w_old[MSTATUS_MIE]         = r_mst_mie;
        w_old[MSTATUS_MPIE]        = r_mst_mpie;
      end
      IDX_MISA:      w_old = ISA_VAL;
      IDX_MIE:       w_old = r_mie;
      IDX_MTVEC:     w_old = r_mtvec;
      IDX_MSCRATCH:  w_old = r_mscratch;
      IDX_MEPC:      w_old = r_mepc;
      IDX_MCAUSE:    w_old = r_mcause;
      IDX_MTVAL:     w_old = r_mtval;
      IDX_MIP: begin
        w_old[3]  = s_irq_i[0];
        w_old[7]  = s_irq_i[1];
        w_old[11] = s_irq_i[2];
      end
      IDX_MHRDCTRL0: w_old = r_hrdctrl0;
      IDX_MHARTID:   w_old = HARTID;
`ifdef CSR_COUNTERS_EN
      IDX_MCYCLE:    w_old = w_mcycle[31:0];
      IDX_MCYCLEH:   w_old = w_mcycle[63:32];
      IDX_MINSTRET:  w_old = w_minstret[31:0];
      IDX_MINSTRETH: w_old = w_minstret[63:32];
`endif
      default:       w_mapped = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so read-only CSRs stay legal.
  always_comb begin
    case (r_op)
      CSR_RW:  w_new = r_wdata;
      CSR_RS:  w_new = w_old | r_wdata;
      CSR_RC:  w_new = w_old & ~r_wdata;
      default: w_new = w_old;
    endcase
  end

  assign w_wr_eff = (r_op == CSR_RW) || (r_wdata != '0);
  assign w_ill    = !w_mapped || (r_op == 2'b00) || (w_wr_eff && (r_add[11:10] == 2'b11));
  assign w_commit = (r_state == ST_ACCESS) && !w_ill && w_wr_eff;

  always_ff @(posedge s_clk_i) begin
    if (r_state == ST_IDLE && s_bus.s_req_val_i) begin
      r_op    <= s_bus.s_req_op_i;
      r_add   <= s_bus.s_req_add_i;
      r_wdata <= s_bus.s_req_wdata_i;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      r_state     <= ST_IDLE;
      r_req_rdy   <= 1'b1;
      r_rsp_val   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_ill   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (s_bus.s_req_val_i) begin
          r_state   <= ST_ACCESS;
          r_req_rdy <= 1'b0;
        end
        ST_ACCESS: begin
          r_state     <= ST_RESP;
          r_rsp_val   <= 1'b1;
          r_rsp_rdata <= w_ill ? '0 : w_old;
          r_rsp_ill   <= w_ill;
        end
        ST_RESP: if (s_bus.s_rsp_rdy_i) begin
          r_state   <= ST_IDLE;
          r_rsp_val <= 1'b0;
          r_req_rdy <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_hrdctrl0 <= '0;
    end else if (w_commit) begin
      case (w_idx)
        IDX_MSTATUS: begin
          r_mst_mie  <= w_new[MSTATUS_MIE];
          r_mst_mpie <= w_new[MSTATUS_MPIE];
        end
        IDX_MIE:       r_mie      <= w_new;
        IDX_MTVEC:     r_mtvec    <= w_new;
        IDX_MSCRATCH:  r_mscratch <= w_new;
        IDX_MEPC:      r_mepc     <= {w_new[31:1], 1'b0};
        IDX_MCAUSE:    r_mcause   <= w_new;
        IDX_MTVAL:     r_mtval    <= w_new;
        IDX_MHRDCTRL0: r_hrdctrl0 <= w_new;
        default: ;
      endcase
    end
  end

  assign s_bus.s_req_rdy_o   = r_req_rdy;
  assign s_bus.s_rsp_val_o   = r_rsp_val;
  assign s_bus.s_rsp_rdata_o = r_rsp_rdata;
  assign s_bus.s_rsp_ill_o   = r_rsp_ill;
  assign s_mtvec_o           = r_mtvec;
  assign s_mepc_o            = r_mepc;
  assign s_mie_o             = r_mie;
  assign s_hrdctrl0_o        = r_hrdctrl0;
  assign s_gie_o             = r_mst_mie;
endmodule

// File: tb/tb_csr_access_responder.sv
// Directed + random bench for csr_access_responder against a rule-level CSR model.
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_access_responder;
  localparam logic [31:0] HART = 32'h0000_0005;
  localparam logic [31:0] ISA  = 32'h40001106;
  localparam logic [31:0] MTV  = 32'h80000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        retire = 1'b0;
  logic [2:0]  irq = 3'b000;
  logic [31:0] mtvec, mepc, mie, hrd;
  logic        gie;

  csr_access_responder_if bus();

  csr_access_responder #(.HARTID(HART), .ISA_VAL(ISA), .MTVEC_RST(MTV)) dut (
    .s_clk_i(clk), .s_resetn_i(resetn), .s_bus(bus), .s_retire_i(retire),
    .s_irq_i(irq), .s_mtvec_o(mtvec), .s_mepc_o(mepc), .s_mie_o(mie),
    .s_hrdctrl0_o(hrd), .s_gie_o(gie)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit ret_hist [0:65535];
  bit ret_en = 1'b0;
  always @(posedge clk) begin
    #1;
    retire = ret_en ? 1'($urandom_range(0, 1)) : 1'b0;
    ret_hist[cyc] = retire;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: register contents by address, counters as (value, cycle of last write).
  logic [31:0]     m_reg [0:4095];
  logic [31:0]     m_st;
  longint unsigned cV [2];
  int              cW [2];

  function automatic longint unsigned cnt_at(input int i, input int c);
    longint unsigned v = cV[i];
    if (i == 0) v = v + 64'(c - cW[0] - 1);
    else for (int k = cW[1] + 1; k < c; k++) if (ret_hist[k]) v = v + 1;
    return v;
  endfunction

  function automatic bit m_mapped(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'h7C0, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, input int c);
    longint unsigned t;
    case (a)
      12'h300: return 32'h1800 | m_st;
      12'h301: return ISA;
      12'h344: return {20'd0, irq[2], 3'd0, irq[1], 3'd0, irq[0], 3'd0};
      12'hF14: return HART;
      12'hB00: begin t = cnt_at(0, c); return t[31:0];  end
      12'hB80: begin t = cnt_at(0, c); return t[63:32]; end
      12'hB02: begin t = cnt_at(1, c); return t[31:0];  end
      12'hB82: begin t = cnt_at(1, c); return t[63:32]; end
      default: return m_reg[a];
    endcase
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [31:0] v, input int c);
    longint unsigned t;
    int i;
    case (a)
      12'h300: m_st = v & 32'h88;
      12'h341: m_reg[a] = v & ~32'h1;
      12'h301, 12'h344, 12'hF14: ;
      12'hB00, 12'hB80, 12'hB02, 12'hB82: begin
        i = (a[1] == 1'b1) ? 1 : 0;
        t = cnt_at(i, c);
        if (a[7]) t[63:32] = v; else t[31:0] = v;
        cV[i] = t;
        cW[i] = c;
      end
      default: m_reg[a] = v;
    endcase
  endfunction

  function automatic void m_reset(input int cr);
    for (int k = 0; k < 4096; k++) m_reg[k] = 32'd0;
    m_reg[12'h305] = MTV;
    m_st = 32'd0;
    cV[0] = 0; cV[1] = 0;
    cW[0] = cr; cW[1] = cr;
  endfunction

  task automatic do_reset();
    int cr;
    @(negedge clk);
    resetn = 1'b0;
    cr = cyc;
    @(negedge clk);
    resetn = 1'b1;
    m_reset(cr);
  endtask

  task automatic chk_exports(input string tag);
    chk({tag, "_mtvec"}, mtvec, m_reg[12'h305]);
    chk({tag, "_mepc"},  mepc,  m_reg[12'h341]);
    chk({tag, "_mie"},   mie,   m_reg[12'h304]);
    chk({tag, "_hrd"},   hrd,   m_reg[12'h7C0]);
    chk({tag, "_gie"},   gie,   m_st[3]);
  endtask

  // One request; leaves s_req_val_i high after a held response so the next call re-presents it.
  task automatic do_req(input logic [1:0] op, input logic [11:0] add, input logic [31:0] wd,
                        input int hold, output logic [31:0] ordata, output logic oill);
    int hc, n;
    logic [31:0] eold, enew;
    logic eff, eill;
    bus.s_req_op_i    = op;
    bus.s_req_add_i   = add;
    bus.s_req_wdata_i = wd;
    bus.s_req_val_i   = 1'b1;
    bus.s_rsp_rdy_i   = (hold == 0);
    n = 0;
    while (!bus.s_req_rdy_o && n < 20) begin @(negedge clk); n++; end
    if (!bus.s_req_rdy_o) begin
      chk("hs_timeout", bus.s_req_rdy_o, 1'b1);
      ordata = '0; oill = 1'b0;
      return;
    end
    hc = cyc;
    @(posedge clk); #1;
    bus.s_req_val_i = 1'b0;
    @(negedge clk);
    chk("lat_access_val", bus.s_rsp_val_o, 1'b0);
    chk("lat_access_rdy", bus.s_req_rdy_o, 1'b0);
    @(negedge clk);
    chk("lat_rsp_val", bus.s_rsp_val_o, 1'b1);
    eold = m_read(add, hc + 1);
    eff  = (op == 2'b01) || (wd != 32'd0);
    eill = !m_mapped(add) || (op == 2'b00) || (eff && add[11:10] == 2'b11);
    if (eill) eold = 32'd0;
    else if (eff) begin
      case (op)
        2'b01:   enew = wd;
        2'b10:   enew = eold | wd;
        default: enew = eold & ~wd;
      endcase
      m_write(add, enew, hc + 1);
    end
    chk("rsp_rdata", bus.s_rsp_rdata_o, eold);
    chk("rsp_ill",   bus.s_rsp_ill_o,   eill);
    ordata = bus.s_rsp_rdata_o;
    oill   = bus.s_rsp_ill_o;
    if (hold > 0) begin
      bus.s_req_val_i = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_val",   bus.s_rsp_val_o,   1'b1);
        chk("hold_rdata", bus.s_rsp_rdata_o, eold);
        chk("hold_ill",   bus.s_rsp_ill_o,   eill);
        chk("hold_rdy",   bus.s_req_rdy_o,   1'b0);
      end
      bus.s_rsp_rdy_i = 1'b1;
    end
    @(negedge clk);
    chk("idle_rdy", bus.s_req_rdy_o, 1'b1);
    chk("idle_val", bus.s_rsp_val_o, 1'b0);
    chk_exports("exp");
  endtask

  logic [31:0] rd, rd2;
  logic        il;
  logic [11:0] addrs [16];
  int          hc0;

  initial begin
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'h7C0, 12'hF14, 12'hB00, 12'hB82, 12'hB02, 12'h123, 12'h7C1};
    bus.s_req_val_i = 1'b0; bus.s_req_op_i = 2'b00; bus.s_req_add_i = '0;
    bus.s_req_wdata_i = '0; bus.s_rsp_rdy_i = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    chk("rst_rdy",   bus.s_req_rdy_o,   1'b1);
    chk("rst_val",   bus.s_rsp_val_o,   1'b0);
    chk("rst_rdata", bus.s_rsp_rdata_o, 32'd0);
    chk("rst_ill",   bus.s_rsp_ill_o,   1'b0);
    chk("rst_mtvec", mtvec, MTV);
    chk("rst_gie",   gie,   1'b0);

    do_req(2'b10, 12'h305, 32'd0, 0, rd, il);
    chk("mtvec_read", rd, 32'h80000000);
    chk("mtvec_keep", mtvec, 32'h80000000);

    do_req(2'b01, 12'h340, 32'hDEADBEEF, 0, rd, il);
    do_req(2'b11, 12'h340, 32'h0000FFFF, 0, rd, il);
    chk("rc_old", rd, 32'hDEADBEEF);
    do_req(2'b10, 12'h340, 32'd0, 0, rd, il);
    chk("rc_result", rd, 32'hDEAD0000);

    do_req(2'b01, 12'hF14, 32'd1, 0, rd, il);
    chk("ro_write_ill", il, 1'b1);
    chk("ro_write_rd", rd, 32'd0);
    do_req(2'b10, 12'hF14, 32'd0, 0, rd, il);
    chk("hartid", rd, HART);
    chk("hartid_ill", il, 1'b0);
    do_req(2'b10, 12'h123, 32'd0, 0, rd, il);
    chk("unmapped_ill", il, 1'b1);
    do_req(2'b00, 12'h340, 32'd0, 0, rd, il);
    chk("op00_ill", il, 1'b1);
    do_req(2'b01, 12'h300, 32'hFFFFFFFF, 0, rd, il);
    do_req(2'b10, 12'h300, 32'd0, 0, rd, il);
    chk("mstatus_mask", rd, 32'h00001888);

`ifdef CSR_COUNTERS_EN
    do_req(2'b01, 12'hB80, 32'hFFFFFFFF, 0, rd, il);
    do_req(2'b01, 12'hB00, 32'hFFFFFFFF, 0, rd, il);
    do_req(2'b10, 12'hB80, 32'd0, 0, rd, il);
    chk("mcycleh_wrap", rd, 32'd0);
    do_req(2'b10, 12'hB00, 32'd0, 0, rd, il);
    ret_en = 1'b1;
    do_req(2'b01, 12'hB82, 32'hFFFFFFFF, 0, rd, il);
    do_req(2'b01, 12'hB02, 32'hFFFFFFFF, 0, rd, il);
    repeat (12) @(negedge clk);
    do_req(2'b10, 12'hB82, 32'd0, 0, rd, il);
    ret_en = 1'b0;
    repeat (3) @(negedge clk);
    do_req(2'b10, 12'hB02, 32'd0, 0, rd, il);
    repeat (5) @(negedge clk);
    do_req(2'b10, 12'hB02, 32'd0, 0, rd2, il);
    chk("minstret_idle", rd2, rd);
`else
    do_req(2'b10, 12'hB00, 32'd0, 0, rd, il);
    chk("nocnt_ill", il, 1'b1);
    do_req(2'b01, 12'hB82, 32'd7, 0, rd, il);
    chk("nocnt_ill_wr", il, 1'b1);
`endif

    do_req(2'b01, 12'h342, 32'h0BADF00D, 5, rd, il);
    do_req(2'b01, 12'h342, 32'h0BADF00D, 0, rd, il);
    chk("held_req_once", rd, 32'h0BADF00D);

    // Reset during ACCESS aborts the write.
    bus.s_req_op_i = 2'b01; bus.s_req_add_i = 12'h341; bus.s_req_wdata_i = 32'h1235;
    bus.s_req_val_i = 1'b1; bus.s_rsp_rdy_i = 1'b1;
    hc0 = cyc;
    @(posedge clk); #1;
    bus.s_req_val_i = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    m_reset(hc0 + 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", bus.s_rsp_val_o, 1'b0);
    end
    chk("abort_mepc", mepc, 32'd0);
    chk("abort_mtvec", mtvec, MTV);
    do_req(2'b01, 12'h341, 32'h1235, 0, rd, il);
    chk("mepc_bit0", mepc, 32'h00001234);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [11:0] a;
      logic [31:0] w;
      op  = 2'($urandom_range(0, 3));
      a   = addrs[$urandom_range(0, 15)];
      w   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      irq = 3'($urandom_range(0, 7));
      ret_en = 1'($urandom_range(0, 1));
      do_req(op, a, w, ($urandom_range(0, 4) == 0) ? 2 : 0, rd, il);
      bus.s_req_val_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_access_responder.md
# csr_access_responder

Responder side of the CSR access protocol. Accepts CSR requests (operation, 12-bit machine-level CSR address, write operand), decodes the address to the internal machine-CSR register, and performs the read-modify-write. It owns the machine CSR storage and the 64-bit cycle/instret counters, and returns the old value or an illegal-access flag. It sits between the execute stage's CSR requester and the trap/fetch logic, which consume the exported trap-vector, EPC, and interrupt-enable state.

## Interface
- HARTID, 0, value read from mhartid (0xF14)
- ISA_VAL, 32'h40001106, value read from misa (0x301): RV32 I, M, C, B
- MTVEC_RST, 32'h80000000, reset value of mtvec
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset; one clock, reset is synchronous and active-low
- s_req_val_i  in  1  request valid
- s_req_rdy_o  out  1  request ready; high only in IDLE
- s_req_op_i  in  2  operation: CSR_RW=01, CSR_RS=10, CSR_RC=11; 00 is illegal
- s_req_add_i  in  12  CSR address
- s_req_wdata_i  in  32  write operand
- s_rsp_val_o  out  1  response valid
- s_rsp_rdy_i  in  1  response accepted
- s_rsp_rdata_o  out  32  old CSR value; 0 when illegal
- s_rsp_ill_o  out  1  illegal access
- s_retire_i  in  1  instruction retired this cycle
- s_irq_i  in  3  {MEI, MTI, MSI} pending lines
- s_mtvec_o, s_mepc_o, s_mie_o, s_hrdctrl0_o  out  32 each  live register contents
- s_gie_o  out  1  mstatus.MIE

## Operation
- FSM states:
  - IDLE: s_req_rdy_o=1. On handshake, latch op/add/wdata and go to ACCESS.
  - ACCESS: read the old value and compute the new one. RW: new=wdata. RS: old|wdata. RC: old&~wdata. Commit at the clock edge, then go to RESP.
  - RESP: s_rsp_val_o=1 with stable data. On s_rsp_rdy_i, go to IDLE.
- Write is suppressed for RS/RC with wdata==0. This is not illegal, even on read-only CSRs.
- Illegal cases, each giving rdata=0 and no state change:
  - unmapped address
  - op=00
  - an effective write to an address with add[11:10]==2'b11
- Mapped CSRs:
  - mstatus 0x300: MIE bit3 and MPIE bit7 writable; MPP 12:11 reads 2'b11; all other bits 0.
  - misa 0x301: ISA_VAL; writes legal but ignored.
  - mie 0x304, mtvec 0x305, mscratch 0x340, mcause 0x342, mtval 0x343, mhrdctrl0 0x7C0: full 32-bit.
  - mepc 0x341: bit0 forced 0.
  - mip 0x344: reads s_irq_i on bits 3/7/11; writes legal but ignored.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - mhartid 0xF14: read-only.
- Counters are 64 bits and wrap from 2^64-1 to 0.
  - mcycle increments every cycle.
  - minstret increments when s_retire_i=1.
  - A write to either half in the ACCESS cycle replaces that half. The counter does not increment in that cycle, and the other half holds.
- Counter reads return the value present during the ACCESS cycle.

## Timing
- Latency: handshake in cycle 0, commit at the end of cycle 1, s_rsp_val_o in cycle 2. Minimum throughput is one request per 3 cycles.
- s_rsp_* are held stable while s_rsp_val_o=1 and s_rsp_rdy_i=0.
- s_req_rdy_o=0 outside IDLE. A request is not accepted in the same cycle as a response handshake.
- Exported s_*_o values reflect a committed write from cycle 2 onward.
- Reset values:
  - FSM IDLE; s_req_rdy_o=1, s_rsp_val_o=0, s_rsp_rdata_o=0, s_rsp_ill_o=0.
  - mtvec=MTVEC_RST; every other register 0; s_gie_o=0.
- Reset asserted mid-transaction aborts it: no commit, no response, registers take reset values on the next edge.

## Configuration
- CSR_COUNTERS_EN defined: the counters and their four addresses exist as above.
- Undefined: no counter flops. 0xB00/0xB02/0xB80/0xB82 are unmapped and always illegal, and s_retire_i is ignored.

## Structure
- p_hardisc holds:
  - CSR operation codes and full 12-bit CSR address constants
  - machine-CSR index enumeration
  - the FSM state typedef (IDLE/ACCESS/RESP)
  - the mstatus bit positions
- Sub-module csr_counter64: 64-bit counter with increment enable and independent low/high 32-bit write ports; instantiated twice.

## Test plan
- After reset, RS 0x305 with wdata 0 → rdata 0x80000000, ill=0, response in cycle 2; mtvec unchanged.
- RW 0x340 with 0xDEADBEEF, then RC 0x340 with 0x0000FFFF → second rdata 0xDEADBEEF; then RS with 0 reads 0xDEAD0000.
- RW 0xF14 with 1 → ill=1, rdata 0. RS 0xF14 with 0 → rdata HARTID, ill=0. Address 0x123, or op 00 → ill=1.
- RW 0xB00 with 0xFFFFFFFF, 0xB80 with 0xFFFFFFFF → after the next increment the counter wraps to 0 with no stuck carry. minstret advances only on s_retire_i pulses. With CSR_COUNTERS_EN undefined, 0xB00 → ill=1.
- Hold s_rsp_rdy_i=0 for 5 cycles → rsp stable, s_req_rdy_o=0; s_req_val_i held high is accepted only once rdy returns.
- Assert s_resetn_i=0 during ACCESS of RW 0x341 with 0x1235 → no response, mepc=0. Repeat without reset → s_mepc_o=0x00001234.
